// File: rtl/core_pkg.sv
// Shared definitions for the dCPU core: sequencer state encoding, latched
// decoder-flag bundle and the opcode constants used by the decoder.
package core_pkg;

   // Sequencer states; codes 6 and 7 are illegal and recover to ST_FETCH.
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   localparam int STATE_W = 3;

   // Decoder classification flags, captured once per instruction in DECODE.
   typedef struct packed {
      logic reg_we;
      logic is_load;
      logic is_store;
      logic is_muldiv;
      logic is_system;
   } dec_flags_t;

   // Major opcodes recognised by the combinational decoder.
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // Where an instruction goes once its execute phase is complete.
   function automatic state_e exec_exit(input dec_flags_t f);
      return (f.is_load || f.is_store) ? ST_MEM : ST_WB;
   endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the dCPU core.
// Build option: define SYSTEM_HALT_EN to make system instructions halt the core.
module core_sequencer
   import core_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   input  logic                imem_ack,
   output logic                ir_we,
   input  logic                dec_reg_we,
   input  logic                dec_is_load,
   input  logic                dec_is_store,
   input  logic                dec_is_muldiv,
   input  logic                dec_is_system,
   output logic                alu_start,
   input  logic                alu_done,
   output logic                dmem_req,
   output logic                dmem_we,
   input  logic                dmem_ack,
   output logic                rf_we,
   output logic                pc_we,
   output logic                halted,
   output logic [STATE_W-1:0]  state,
   output logic [RETIRE_W-1:0] instret
);

`ifdef SYSTEM_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   state_e              state_q, state_d;
   dec_flags_t          flags_q, flags_d;
   logic                alu_busy_q, alu_busy_d;   // alu_start already issued
   logic [RETIRE_W-1:0] instret_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         flags_q    <= '0;
         alu_busy_q <= 1'b0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         flags_q    <= flags_d;
         alu_busy_q <= alu_busy_d;
         if (state_q == ST_WB)
            instret_q <= instret_q + RETIRE_W'(1);
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      flags_d    = flags_q;
      alu_busy_d = 1'b0;
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      alu_start  = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      pc_we      = 1'b0;
      halted     = 1'b0;

      case (state_q)
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end
         end

         ST_DECODE: begin
            flags_d.reg_we    = dec_reg_we;
            flags_d.is_load   = dec_is_load;
            flags_d.is_store  = dec_is_store;
            flags_d.is_muldiv = dec_is_muldiv;
            flags_d.is_system = dec_is_system;
            if (HALT_EN && dec_is_system)
               state_d = ST_HALT;
            else
               state_d = ST_EXEC;
         end

         ST_EXEC: begin
            if (flags_q.is_muldiv) begin
               // A done seen in the launch cycle belongs to no op of ours.
               alu_start  = !alu_busy_q;
               alu_busy_d = 1'b1;
               if (alu_busy_q && alu_done) begin
                  alu_busy_d = 1'b0;
                  state_d    = exec_exit(flags_q);
               end
            end else begin
               state_d = exec_exit(flags_q);
            end
         end

         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = flags_q.is_store;
            if (dmem_ack)
               state_d = ST_WB;
         end

         ST_WB: begin
            rf_we   = flags_q.reg_we && !flags_q.is_store;
            pc_we   = 1'b1;
            state_d = ST_FETCH;
         end

         ST_HALT: begin
            halted  = HALT_EN;
            state_d = HALT_EN ? ST_HALT : ST_FETCH;
         end

         default: state_d = ST_FETCH;
      endcase

      // Reset aborts whatever is in flight: nothing is requested or written.
      if (rst) begin
         imem_req  = 1'b0;
         ir_we     = 1'b0;
         alu_start = 1'b0;
         dmem_req  = 1'b0;
         dmem_we   = 1'b0;
         rf_we     = 1'b0;
         pc_we     = 1'b0;
         halted    = 1'b0;
      end
   end

   assign state   = state_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed per-cycle vectors queue their
// expected outputs; a negedge monitor pops and compares against two instances.
`timescale 1ns/1ps
module tb_core_sequencer;
   import core_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, imem_ack, alu_done, dmem_ack;
   logic dec_reg_we, dec_is_load, dec_is_store, dec_is_muldiv, dec_is_system;

   logic        imem_req, ir_we, alu_start, dmem_req, dmem_we, rf_we, pc_we, halted;
   logic [2:0]  state;
   logic [31:0] instret;

   logic        w_imem_req, w_ir_we, w_alu_start, w_dmem_req, w_dmem_we, w_rf_we, w_pc_we, w_halted;
   logic [2:0]  w_state;
   logic [1:0]  w_instret;

   core_sequencer #(.RETIRE_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
      .dec_reg_we(dec_reg_we), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
      .dec_is_muldiv(dec_is_muldiv), .dec_is_system(dec_is_system),
      .alu_start(alu_start), .alu_done(alu_done),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .pc_we(pc_we), .halted(halted),
      .state(state), .instret(instret)
   );

   // Narrow retire counter so the wrap from all-ones to zero is reachable.
   core_sequencer #(.RETIRE_W(2)) u_wrap (
      .clk(clk), .rst(rst),
      .imem_req(w_imem_req), .imem_ack(imem_ack), .ir_we(w_ir_we),
      .dec_reg_we(dec_reg_we), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
      .dec_is_muldiv(dec_is_muldiv), .dec_is_system(dec_is_system),
      .alu_start(w_alu_start), .alu_done(alu_done),
      .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_ack(dmem_ack),
      .rf_we(w_rf_we), .pc_we(w_pc_we), .halted(w_halted),
      .state(w_state), .instret(w_instret)
   );

   // Input vector bits: {rst, imem_ack, alu_done, dmem_ack, reg_we, load, store, muldiv, system}
   localparam logic [8:0] I_NONE   = 9'h000;
   localparam logic [8:0] I_RST    = 9'h100;
   localparam logic [8:0] I_IACK   = 9'h080;
   localparam logic [8:0] I_ADONE  = 9'h040;
   localparam logic [8:0] I_DACK   = 9'h020;
   localparam logic [8:0] I_REGWE  = 9'h010;
   localparam logic [8:0] I_LOAD   = 9'h008;
   localparam logic [8:0] I_STORE  = 9'h004;
   localparam logic [8:0] I_MULDIV = 9'h002;
   localparam logic [8:0] I_SYS    = 9'h001;

   // Output vector bits: {imem_req, ir_we, alu_start, dmem_req, dmem_we, rf_we, pc_we, halted}
   localparam logic [7:0] O_NONE   = 8'h00;
   localparam logic [7:0] O_IREQ   = 8'h80;
   localparam logic [7:0] O_IRWE   = 8'h40;
   localparam logic [7:0] O_ASTART = 8'h20;
   localparam logic [7:0] O_DREQ   = 8'h10;
   localparam logic [7:0] O_DWE    = 8'h08;
   localparam logic [7:0] O_RFWE   = 8'h04;
   localparam logic [7:0] O_PCWE   = 8'h02;
   localparam logic [7:0] O_HALT   = 8'h01;

   typedef struct {
      logic [2:0]  st;
      logic [7:0]  outs;
      logic [31:0] ir;
      string       tag;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [31:0] n_ret = 32'd0;
   logic [7:0]  act_outs, w_outs;

   assign act_outs = {imem_req, ir_we, alu_start, dmem_req, dmem_we, rf_we, pc_we, halted};
   assign w_outs   = {w_imem_req, w_ir_we, w_alu_start, w_dmem_req, w_dmem_we, w_rf_we, w_pc_we, w_halted};

   // Drive one cycle of inputs and, if requested, queue what that cycle must show.
   task automatic step(input logic [8:0] in, input logic [2:0] st, input logic [7:0] outs,
                       input string tag, input bit chk = 1'b1);
      exp_t e;
      {rst, imem_ack, alu_done, dmem_ack,
       dec_reg_we, dec_is_load, dec_is_store, dec_is_muldiv, dec_is_system} = in;
      if (chk) begin
         e.st   = st;
         e.outs = outs;
         e.ir   = n_ret;
         e.tag  = tag;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         total++;
         if (state !== cur.st || act_outs !== cur.outs || instret !== cur.ir ||
             w_state !== cur.st || w_outs !== cur.outs || w_instret !== cur.ir[1:0]) begin
            bad++;
            $display("FAIL %s: got st=%0d outs=%b instret=%0d wrap(st=%0d outs=%b instret=%0d), need st=%0d outs=%b instret=%0d wrap_instret=%0d",
                     cur.tag, state, act_outs, instret, w_state, w_outs, w_instret,
                     cur.st, cur.outs, cur.ir, cur.ir[1:0]);
         end
      end
   end

   initial begin
      // Reset: first cycle state unknown, second cycle shows reset values.
      step(I_RST, ST_FETCH, O_NONE, "rst0", 1'b0);
      step(I_RST, ST_FETCH, O_NONE, "rst_cycle");

      // ALU op, imem_ack held high throughout (ignored outside FETCH).
      step(I_IACK,           ST_FETCH,  O_IREQ | O_IRWE, "alu_fetch");
      step(I_IACK | I_REGWE, ST_DECODE, O_NONE,          "alu_decode");
      step(I_IACK,           ST_EXEC,   O_NONE,          "alu_exec");
      step(I_IACK,           ST_WB,     O_RFWE | O_PCWE, "alu_wb");
      n_ret++;

      // Load with dmem_ack three cycles late; a stray ack in EXEC is ignored.
      step(I_IACK,           ST_FETCH,  O_IREQ | O_IRWE, "ld_fetch");
      step(I_REGWE | I_LOAD, ST_DECODE, O_NONE,          "ld_decode");
      step(I_DACK,           ST_EXEC,   O_NONE,          "ld_exec");
      for (int i = 0; i < 3; i++)
         step(I_NONE,        ST_MEM,    O_DREQ,          "ld_mem_wait");
      step(I_DACK,           ST_MEM,    O_DREQ,          "ld_mem_ack");
      step(I_NONE,           ST_WB,     O_RFWE | O_PCWE, "ld_wb");
      n_ret++;

      // Store after one imem wait cycle: dmem_we high, no register write.
      step(I_NONE,            ST_FETCH,  O_IREQ,          "st_fetch_wait");
      step(I_IACK,            ST_FETCH,  O_IREQ | O_IRWE, "st_fetch");
      step(I_REGWE | I_STORE, ST_DECODE, O_NONE,          "st_decode");
      step(I_NONE,            ST_EXEC,   O_NONE,          "st_exec");
      step(I_DACK,            ST_MEM,    O_DREQ | O_DWE,  "st_mem");
      step(I_NONE,            ST_WB,     O_PCWE,          "st_wb");
      n_ret++;

      // Muldiv: spurious done in DECODE and in the start cycle, real done 5 later.
      step(I_IACK,                       ST_FETCH,  O_IREQ | O_IRWE, "md_fetch");
      step(I_REGWE | I_MULDIV | I_ADONE, ST_DECODE, O_NONE,          "md_decode");
      step(I_ADONE,                      ST_EXEC,   O_ASTART,        "md_start");
      for (int i = 0; i < 4; i++)
         step(I_NONE,                    ST_EXEC,   O_NONE,          "md_wait");
      step(I_ADONE,                      ST_EXEC,   O_NONE,          "md_done");
      step(I_NONE,                       ST_WB,     O_RFWE | O_PCWE, "md_wb");
      n_ret++;

`ifdef SYSTEM_HALT_EN
      // System instruction halts; acks are ignored and instret holds.
      step(I_IACK, ST_FETCH,  O_IREQ | O_IRWE, "sys_fetch");
      step(I_SYS,  ST_DECODE, O_NONE,          "sys_decode");
      for (int i = 0; i < 20; i++)
         step(I_IACK | I_DACK | I_ADONE, ST_HALT, O_HALT, "halt_hold");
      step(I_RST,  ST_HALT,   O_NONE,          "halt_rst");
`else
      // System instruction runs as a no-op and retires.
      step(I_IACK,          ST_FETCH,  O_IREQ | O_IRWE, "sys_fetch");
      step(I_SYS | I_REGWE, ST_DECODE, O_NONE,          "sys_decode");
      step(I_NONE,          ST_EXEC,   O_NONE,          "sys_exec");
      step(I_NONE,          ST_WB,     O_RFWE | O_PCWE, "sys_wb");
      n_ret++;
      step(I_RST,           ST_FETCH,  O_NONE,          "sys_rst");
`endif
      n_ret = 32'd0;
      step(I_NONE, ST_FETCH, O_IREQ, "after_rst_fetch");

      // Reset during MEM: request drops in the reset cycle and nothing retires.
      step(I_IACK,           ST_FETCH,  O_IREQ | O_IRWE, "abort_fetch");
      step(I_REGWE | I_LOAD, ST_DECODE, O_NONE,          "abort_decode");
      step(I_NONE,           ST_EXEC,   O_NONE,          "abort_exec");
      step(I_NONE,           ST_MEM,    O_DREQ,          "abort_mem");
      step(I_RST | I_DACK,   ST_MEM,    O_NONE,          "abort_rst");
      step(I_NONE,           ST_FETCH,  O_IREQ,          "abort_refetch");

      // Five back-to-back ALU ops; the 2-bit counter wraps 3 -> 0 on the fourth.
      for (int k = 0; k < 5; k++) begin
         step(I_IACK,  ST_FETCH,  O_IREQ | O_IRWE, "wrap_fetch");
         step(I_REGWE, ST_DECODE, O_NONE,          "wrap_decode");
         step(I_NONE,  ST_EXEC,   O_NONE,          "wrap_exec");
         step(I_NONE,  ST_WB,     O_RFWE | O_PCWE, "wrap_wb");
         n_ret++;
      end
      step(I_NONE, ST_FETCH, O_IREQ, "wrap_final");

      for (int i = 0; i < 4 && exp_q.size() > 0; i++)
         @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending entries, need 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the dCPU core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the instruction-memory and data-memory request/acknowledge handshakes, the multi-cycle ALU start/done handshake, and the register-file, IR and PC write enables. It sits beside the combinational decoder and consumes that decoder's classification flags.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  instruction fetch request; held until acknowledged.
- `imem_ack`  in  1  fetch data valid this cycle.
- `ir_we`  out  1  latch instruction register; one-cycle pulse.
- `dec_reg_we`, `dec_is_load`, `dec_is_store`, `dec_is_muldiv`, `dec_is_system`  in  1 each  decoder flags, valid during DECODE.
- `alu_start`  out  1  one-cycle pulse launching a multi-cycle ALU op.
- `alu_done`  in  1  multi-cycle ALU result valid.
- `dmem_req`  out  1  data access request; held until acknowledged.
- `dmem_we`  out  1  store when 1, load when 0; valid while `dmem_req`=1.
- `dmem_ack`  in  1  data access complete this cycle.
- `rf_we`  out  1  register-file write enable.
- `pc_we`  out  1  PC update enable.
- `halted`  out  1  core stopped.
- `state`  out  3  current FSM state, for debug.
- `instret`  out  RETIRE_W  retired-instruction count.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are illegal and go to FETCH on the next edge.
- FETCH
  - `imem_req`=1.
  - On `imem_ack`: `ir_we`=1 in the same cycle, next state DECODE.
- DECODE
  - Latch the five `dec_*` flags into internal registers. Later states use only these latched copies.
  - If `dec_is_system` and halt is enabled: next state HALT.
  - Otherwise: next state EXEC.
- EXEC
  - If latched muldiv: `alu_start`=1 in the first EXEC cycle only. Stay in EXEC until `alu_done`=1. `alu_done` in the start cycle itself is ignored.
  - If not muldiv: EXEC lasts exactly one cycle.
  - Exit goes to MEM if the instruction is a load or store, otherwise to WB.
- MEM
  - `dmem_req`=1 and `dmem_we`=latched store flag.
  - On `dmem_ack`: next state WB.
- WB
  - `rf_we`=latched `reg_we` AND NOT latched `is_store`.
  - `pc_we`=1.
  - `instret` increments and wraps from all-ones to 0.
  - Next state FETCH.
- HALT: `halted`=1. All request and enable outputs are 0. The block leaves HALT only on `rst`.
- `imem_ack` outside FETCH, `dmem_ack` outside MEM and `alu_done` outside EXEC are ignored.

## Timing
- Reset values:
  - state=FETCH.
  - `instret`=0 and all latched flags=0.
  - `imem_req`, `ir_we`, `alu_start`, `dmem_req`, `dmem_we`, `rf_we`, `pc_we`, `halted` all 0 during the `rst` cycle.
  - `imem_req` rises the first cycle after `rst` deasserts.
- Reset mid-operation aborts any outstanding request. Requests deassert during the `rst` cycle, and no writeback occurs.
- All outputs are decoded from registered state and latched flags, with no combinational path from `*_ack` or `alu_done`. Exception: `ir_we`=`imem_ack` while in FETCH.
- Latency with zero-wait memory (ack in the first request cycle):
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Muldiv: 4 cycles + ALU latency.
- Each wait cycle on `imem_ack`, `dmem_ack` or `alu_done` adds exactly one cycle.

## Configuration
- `SYSTEM_HALT_EN` defined: DECODE with `dec_is_system`=1 goes to HALT. `instret` does not count the halting instruction.
- `SYSTEM_HALT_EN` undefined: system instructions run as a no-op through EXEC and WB. `rf_we` follows the latched `reg_we`, `pc_we`=1, `instret` increments. HALT is unreachable and `halted` is tied to 0.

## Structure
- Shared package `core_pkg`: state encoding constants (FETCH..HALT, 3 bits) and the state enum typedef. The same package also holds the opcode constants used by the decoder.
- No sub-module needed. The latched-flag register and the `instret` counter are small enough to stay inline.

## Test plan
- Reset, then an ALU instruction (`dec_reg_we`=1), with `imem_ack` held 1 → state sequence 0,1,2,4,0. `rf_we`=1 and `pc_we`=1 only in cycle 4. `instret` 0→1.
- Load with `dmem_ack` delayed 3 cycles → `dmem_req`=1 for 4 cycles with `dmem_we`=0. WB one cycle after the ack, with `rf_we`=1. Total 8 cycles.
- Store (`dec_reg_we`=1, `dec_is_store`=1) → `dmem_we`=1 during MEM, and `rf_we`=0 in WB.
- Muldiv with `alu_done` 5 cycles after start, plus a spurious `alu_done` pulse in the start cycle → exactly one `alu_start` pulse. The spurious pulse is ignored and WB follows the real done.
- System instruction with `SYSTEM_HALT_EN` defined → HALT, `halted`=1, and no `imem_req` for 20 cycles. `instret` stays unchanged. `rst` returns to FETCH with `instret`=0.
- `rst` asserted during MEM with `dmem_req`=1 → `dmem_req`=0 during the `rst` cycle, no WB, and FETCH follows the cycle after `rst` deasserts. Also preload `instret` to 2^32-1 and retire one instruction → `instret`=0.
